id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register feeding the ALU (a_in, b_in, f_in, branch, branchcontrol).

---
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: operand capture, stall/flush, EX/MEM and MEM/WB
// forwarding, immediate select and load-use hazard detection. Optional macro: ID_EX_FWD_EN.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [2:0]      id_f,
  input  logic [2:0]      id_bc,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_reg_write,
  input  logic [RA_W-1:0] id_rd,
  input  logic            stall,
  input  logic            flush,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  output logic [XLEN-1:0] a_in,
  output logic [XLEN-1:0] b_in,
  output logic [2:0]      f_in,
  output logic [2:0]      branchcontrol,
  output logic            branch,
  output logic            mem_read,
  output logic            reg_write,
  output logic            valid,
  output logic [RA_W-1:0] rd,
  output logic [XLEN-1:0] rs2_fwd,
  output logic            load_use_stall
);

  localparam int unsigned F_W = 3;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic [F_W-1:0]  f;
    logic [F_W-1:0]  bc;
    logic            branch;
    logic            mem_read;
    logic            reg_write;
    logic [RA_W-1:0] rd;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  stage_t id_cap;

  // Decode slot packed into stage format
  always_comb begin
    id_cap           = '0;
    id_cap.valid     = 1'b1;
    id_cap.rs1       = id_rs1;
    id_cap.rs2       = id_rs2;
    id_cap.rs1_data  = id_rs1_data;
    id_cap.rs2_data  = id_rs2_data;
    id_cap.imm       = id_imm;
    id_cap.alu_src   = id_alu_src;
    id_cap.f         = id_f;
    id_cap.bc        = id_bc;
    id_cap.branch    = id_branch;
    id_cap.mem_read  = id_mem_read;
    id_cap.reg_write = id_reg_write;
    id_cap.rd        = id_rd;
  end

  // Flush beats stall; an empty decode slot loads as a bubble
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d = id_valid ? id_cap : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  logic [XLEN-1:0] rs1_op;
  logic [XLEN-1:0] rs2_op;

`ifdef ID_EX_FWD_EN
  logic exm_hit1;
  logic exm_hit2;
  logic mwb_hit1;
  logic mwb_hit2;

  // Forwarding works off registered sources so held instructions see retiring results
  always_comb begin
    exm_hit1 = exm_reg_write && (exm_rd == stage_q.rs1) && (stage_q.rs1 != '0);
    exm_hit2 = exm_reg_write && (exm_rd == stage_q.rs2) && (stage_q.rs2 != '0);
    mwb_hit1 = mwb_reg_write && (mwb_rd == stage_q.rs1) && (stage_q.rs1 != '0);
    mwb_hit2 = mwb_reg_write && (mwb_rd == stage_q.rs2) && (stage_q.rs2 != '0);
    rs1_op   = stage_q.rs1_data;
    rs2_op   = stage_q.rs2_data;
    if (exm_hit1) begin
      rs1_op = exm_result;
    end else if (mwb_hit1) begin
      rs1_op = mwb_result;
    end
    if (exm_hit2) begin
      rs2_op = exm_result;
    end else if (mwb_hit2) begin
      rs2_op = mwb_result;
    end
  end
`else
  logic unused_fwd;

  always_comb begin
    rs1_op = stage_q.rs1_data;
    rs2_op = stage_q.rs2_data;
  end

  assign unused_fwd = ^{exm_reg_write, exm_rd, exm_result,
                        mwb_reg_write, mwb_rd, mwb_result,
                        stage_q.rs1, stage_q.rs2};
`endif

  logic producer;
  logic hit_rs1;
  logic hit_rs2;
  logic load_hit;

  // Load-use hazard; without forwarding every in-stage writer interlocks
  always_comb begin
    producer = stage_q.valid && (stage_q.rd != '0) && id_valid;
    hit_rs1  = (stage_q.rd == id_rs1);
    hit_rs2  = (stage_q.rd == id_rs2);
    load_hit = producer && stage_q.mem_read && (hit_rs1 || (hit_rs2 && !id_alu_src));
`ifdef ID_EX_FWD_EN
    load_use_stall = load_hit;
`else
    load_use_stall = load_hit || (producer && stage_q.reg_write && (hit_rs1 || hit_rs2));
`endif
  end

  assign a_in          = rs1_op;
  assign b_in          = stage_q.alu_src ? stage_q.imm : rs2_op;
  assign rs2_fwd       = rs2_op;
  assign f_in          = stage_q.f;
  assign branchcontrol = stage_q.bc;
  assign branch        = stage_q.branch;
  assign mem_read      = stage_q.mem_read;
  assign reg_write     = stage_q.reg_write;
  assign valid         = stage_q.valid;
  assign rd            = stage_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand sequences for reset/forwarding/hazards,
// then random traffic against a behavioural model. Honours ID_EX_FWD_EN like the design.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [2:0]  id_f, id_bc;
  logic        id_branch, id_mem_read, id_reg_write;
  logic        stall, flush;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] a_in, b_in, rs2_fwd;
  logic [2:0]  f_in, branchcontrol;
  logic        branch, mem_read, reg_write, valid, load_use_stall;
  logic [4:0]  rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_f(id_f), .id_bc(id_bc), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_rd(id_rd),
    .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .a_in(a_in), .b_in(b_in), .f_in(f_in), .branchcontrol(branchcontrol),
    .branch(branch), .mem_read(mem_read), .reg_write(reg_write), .valid(valid),
    .rd(rd), .rs2_fwd(rs2_fwd), .load_use_stall(load_use_stall)
  );

  // Behavioural view of the instruction sitting in the stage
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        alu_src;
    logic [2:0]  f, bc;
    logic        br, mr, rw;
    logic [4:0]  rd;
  } model_t;

  typedef struct {
    logic        stall, flush, idv;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        alu_src;
    logic [2:0]  f;
    logic        rw, mr;
    logic [31:0] ea, eb;
    logic [2:0]  ef;
    logic        ev;
  } vec_t;

  model_t m;
  vec_t   tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src = 0;
    id_f = 0; id_bc = 0; id_branch = 0; id_mem_read = 0; id_reg_write = 0;
    stall = 0; flush = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
    if (rs == 5'd0) return rf;
    if (exm_reg_write && exm_rd == rs) return exm_result;
    if (mwb_reg_write && mwb_rd == rs) return mwb_result;
`endif
    return rf;
  endfunction

  function automatic logic exp_lus();
    logic prod, u1, u2, e;
    prod = m.valid && (m.rd != 5'd0) && id_valid;
    u1 = (m.rd == id_rs1);
    u2 = (m.rd == id_rs2);
    e = prod && m.mr && (u1 || (u2 && !id_alu_src));
`ifndef ID_EX_FWD_EN
    e = e || (prod && m.rw && (u1 || u2));
`endif
    return e;
  endfunction

  task automatic check_model(input int n);
    logic [31:0] r2;
    r2 = operand(m.rs2, m.d2);
    chk($sformatf("rnd%0d.a_in", n), a_in, operand(m.rs1, m.d1));
    chk($sformatf("rnd%0d.b_in", n), b_in, m.alu_src ? m.imm : r2);
    chk($sformatf("rnd%0d.rs2_fwd", n), rs2_fwd, r2);
    chk($sformatf("rnd%0d.f_in", n), 32'(f_in), 32'(m.f));
    chk($sformatf("rnd%0d.bc", n), 32'(branchcontrol), 32'(m.bc));
    chk($sformatf("rnd%0d.ctl", n), 32'({valid, branch, mem_read, reg_write}),
        32'({m.valid, m.br, m.mr, m.rw}));
    chk($sformatf("rnd%0d.rd", n), 32'(rd), 32'(m.rd));
    chk($sformatf("rnd%0d.lus", n), 32'(load_use_stall), 32'(exp_lus()));
  endtask

  task automatic model_step();
    if (flush) m = '0;
    else if (!stall) begin
      if (id_valid)
        m = '{valid: 1'b1, rs1: id_rs1, rs2: id_rs2, d1: id_rs1_data, d2: id_rs2_data,
              imm: id_imm, alu_src: id_alu_src, f: id_f, bc: id_bc, br: id_branch,
              mr: id_mem_read, rw: id_reg_write, rd: id_rd};
      else m = '0;
    end
  endtask

  initial begin
    // stall flush idv rs1 rs2 rd d1 d2 imm alu_src f rw mr | a b f valid
    tbl[0] = '{0,0,1, 1,2,6, 32'd5, 32'd9, 32'd7, 1, 3'b010, 1,0, 32'd5, 32'd7, 3'b010, 1};
    tbl[1] = '{1,0,1, 1,2,7, 32'h11, 32'h22, 32'd0, 0, 3'b011, 1,0, 32'd5, 32'd7, 3'b010, 1};
    tbl[2] = '{1,0,1, 1,2,7, 32'h11, 32'h22, 32'd0, 0, 3'b011, 1,0, 32'd5, 32'd7, 3'b010, 1};
    tbl[3] = '{0,0,1, 1,2,7, 32'h11, 32'h22, 32'd0, 0, 3'b011, 1,0, 32'h11, 32'h22, 3'b011, 1};
    tbl[4] = '{1,1,1, 1,2,7, 32'h33, 32'h44, 32'd1, 0, 3'b101, 1,1, 32'd0, 32'd0, 3'b000, 0};
    tbl[5] = '{0,0,0, 1,2,7, 32'h33, 32'h44, 32'd1, 0, 3'b101, 1,1, 32'd0, 32'd0, 3'b000, 0};
    tbl[6] = '{0,0,1, 1,2,8, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 0, 3'b111, 1,0,
               32'hFFFF_FFFF, 32'h8000_0000, 3'b111, 1};
    tbl[7] = '{0,1,1, 1,2,8, 32'h1, 32'h2, 32'd3, 1, 3'b001, 1,0, 32'd0, 32'd0, 3'b000, 0};

    clear_inputs();
    reset = 1;
    #2;
    chk("reset.valid", 32'(valid), 0);
    chk("reset.a_in", a_in, 0);
    chk("reset.ctl", 32'({reg_write, branch, mem_read, f_in, rd}), 0);
    #10 reset = 0;
    tick();
    chk("post_reset.valid", 32'(valid), 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      stall = tbl[i].stall; flush = tbl[i].flush; id_valid = tbl[i].idv;
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; id_rd = tbl[i].rd;
      id_rs1_data = tbl[i].d1; id_rs2_data = tbl[i].d2; id_imm = tbl[i].imm;
      id_alu_src = tbl[i].alu_src; id_f = tbl[i].f;
      id_reg_write = tbl[i].rw; id_mem_read = tbl[i].mr;
      tick();
      chk($sformatf("tbl%0d.a_in", i), a_in, tbl[i].ea);
      chk($sformatf("tbl%0d.b_in", i), b_in, tbl[i].eb);
      chk($sformatf("tbl%0d.f_in", i), 32'(f_in), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d.valid", i), 32'(valid), 32'(tbl[i].ev));
    end

    // Async reset in the middle of a live instruction
    clear_inputs();
    id_valid = 1; id_rs1_data = 32'h77; id_f = 3'b110; id_reg_write = 1; id_rd = 5'd9;
    tick();
    chk("arst.pre_valid", 32'(valid), 1);
    reset = 1;
    #1;
    chk("arst.valid", 32'(valid), 0);
    chk("arst.a_in", a_in, 0);
    chk("arst.ctl", 32'({reg_write, f_in, rd}), 0);
    #1 reset = 0;
    stall = 1;
    tick();
    chk("arst.held_bubble", 32'(valid), 0);
    stall = 0;
    tick();
    chk("arst.reload", 32'(valid), 1);

    // Forwarding priority on rs1 and rs2
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd3; id_rs1_data = 32'h55; id_rs2 = 5'd3; id_rs2_data = 32'h66;
    id_alu_src = 1; id_imm = 32'h99;
    tick();
    id_valid = 0;
    exm_reg_write = 1; exm_rd = 5'd3; exm_result = 32'hAA;
    mwb_reg_write = 1; mwb_rd = 5'd3; mwb_result = 32'hBB;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd.exm_wins", a_in, 32'hAA);
    chk("fwd.rs2_store", rs2_fwd, 32'hAA);
`else
    chk("fwd.off_a", a_in, 32'h55);
    chk("fwd.off_rs2", rs2_fwd, 32'h66);
`endif
    chk("fwd.b_imm", b_in, 32'h99);
    exm_reg_write = 0;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd.mwb", a_in, 32'hBB);
`else
    chk("fwd.off_mwb", a_in, 32'h55);
`endif
    id_valid = 1; id_rs1 = 5'd0; id_rs1_data = 32'h12; exm_reg_write = 1; exm_rd = 5'd0;
    mwb_rd = 5'd0;
    tick();
    chk("fwd.x0", a_in, 32'h12);

    // Load-use and interlock
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd4;
    tick();
    id_mem_read = 0; id_reg_write = 0; id_rd = 0;
    id_rs1 = 5'd4; stall = 1;
    #1 chk("lu.rs1", 32'(load_use_stall), 1);
    id_rs1 = 5'd0; id_rs2 = 5'd4; id_alu_src = 1;
    #1;
`ifdef ID_EX_FWD_EN
    chk("lu.rs2_imm", 32'(load_use_stall), 0);
`else
    chk("lu.rs2_imm_interlock", 32'(load_use_stall), 1);
`endif
    id_alu_src = 0;
    #1 chk("lu.rs2", 32'(load_use_stall), 1);
    id_valid = 0;
    #1 chk("lu.no_id", 32'(load_use_stall), 0);
    stall = 0; id_valid = 1; id_reg_write = 1; id_rd = 5'd5; id_rs2 = 0;
    tick();
    id_reg_write = 0; id_rd = 0; id_rs1 = 5'd5;
    #1;
`ifdef ID_EX_FWD_EN
    chk("raw.alu_prod", 32'(load_use_stall), 0);
`else
    chk("raw.alu_prod", 32'(load_use_stall), 1);
`endif
    flush = 1; stall = 1;
    tick();
    chk("flush_stall.ctl", 32'({valid, reg_write, branch}), 0);

    // Random traffic against the model
    clear_inputs();
    flush = 1;
    tick();
    m = '0;
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_src = 1'($urandom); id_f = 3'($urandom); id_bc = 3'($urandom);
      id_branch = 1'($urandom); id_mem_read = 1'($urandom); id_reg_write = 1'($urandom);
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 7) == 0);
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      mwb_reg_write = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_result = $urandom;
      #1;
      check_model(n);
      model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
